// File: rtl/ppwm_prog_tx.sv
// ppwm_prog_tx -- serial programming transmitter for the ppwm instruction memory.
//
// Takes instruction words from a valid/ready stream and sends each one on a
// single wire. A frame is a high start bit, then WIDTH data bits LSB first,
// then GAP_BITS low bit periods. The line idles low. After DEPTH words,
// word_idx_o wraps to 0 and done_o pulses for one cycle.
//
// Optional feature: define PPWM_PROG_TX_PARITY_EN to add an even-parity bit
// between the data bits and the gap. The parity bit is the XOR of all data
// bits. The receiver must be built to match.
//
// Ports:
//   clk          in   clock, rising edge
//   rst          in   asynchronous reset, active high
//   word_i       in   [WIDTH] instruction word, sampled only on the handshake
//   word_valid_i in   word_i is valid
//   word_ready_o out  high only in IDLE, and low while rst is high
//   ser_o        out  serial programming line (registered)
//   busy_o       out  a frame or gap is in progress (registered)
//   word_idx_o   out  [$clog2(DEPTH)] index of the next word to be accepted
//   done_o       out  one-cycle pulse in the first IDLE cycle after word DEPTH-1
module ppwm_prog_tx #(
  parameter int WIDTH        = 6,
  parameter int DEPTH        = 32,
  parameter int CLKS_PER_BIT = 1,
  parameter int GAP_BITS     = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         word_i,
  input  logic                     word_valid_i,
  output logic                     word_ready_o,
  output logic                     ser_o,
  output logic                     busy_o,
  output logic [$clog2(DEPTH)-1:0] word_idx_o,
  output logic                     done_o
);

  localparam int IDX_W   = $clog2(DEPTH);
  localparam int GAP_CYC = GAP_BITS * CLKS_PER_BIT;
  // The gap is the longest period that is timed, so it sets the counter width.
  localparam int CNT_W   = $clog2(GAP_CYC + 1);
  localparam int BIT_W   = $clog2(WIDTH + 1);

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYC - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(WIDTH - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DEPTH - 1);

`ifdef PPWM_PROG_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_GAP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_GAP} state_t;
`endif

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_nx;
  logic [CNT_W-1:0] clk_cnt;
  logic [BIT_W-1:0] bit_cnt;
  logic             hs;
  logic             bit_end;
`ifdef PPWM_PROG_TX_PARITY_EN
  logic             par_q;
`endif

  // Ready is decoded from the state register. It is gated by rst so that it
  // stays low for the whole time reset is held.
  assign word_ready_o = (state == S_IDLE) && !rst;
  assign hs           = word_valid_i && word_ready_o;
  assign bit_end      = (clk_cnt == BIT_LAST);
  // ser_o is registered, so the next data bit is taken from the shifted value.
  assign shreg_nx     = shreg >> 1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      shreg      <= '0;
      clk_cnt    <= '0;
      bit_cnt    <= '0;
      ser_o      <= 1'b0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      word_idx_o <= '0;
`ifdef PPWM_PROG_TX_PARITY_EN
      par_q      <= 1'b0;
`endif
    end else begin
      done_o <= 1'b0;
      case (state)
        S_IDLE: begin
          ser_o <= 1'b0;
          if (hs) begin
            shreg   <= word_i;
            clk_cnt <= '0;
            bit_cnt <= '0;
            ser_o   <= 1'b1;
            busy_o  <= 1'b1;
            state   <= S_START;
`ifdef PPWM_PROG_TX_PARITY_EN
            par_q   <= ^word_i;
`endif
          end
        end
        S_START: begin
          if (bit_end) begin
            clk_cnt <= '0;
            ser_o   <= shreg[0];
            state   <= S_DATA;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            clk_cnt <= '0;
            shreg   <= shreg_nx;
            if (bit_cnt == DATA_LAST) begin
`ifdef PPWM_PROG_TX_PARITY_EN
              ser_o <= par_q;
              state <= S_PAR;
`else
              ser_o <= 1'b0;
              state <= S_GAP;
`endif
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              ser_o   <= shreg_nx[0];
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
`ifdef PPWM_PROG_TX_PARITY_EN
        S_PAR: begin
          if (bit_end) begin
            clk_cnt <= '0;
            ser_o   <= 1'b0;
            state   <= S_GAP;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
`endif
        S_GAP: begin
          ser_o <= 1'b0;
          if (clk_cnt == GAP_LAST) begin
            clk_cnt <= '0;
            busy_o  <= 1'b0;
            state   <= S_IDLE;
            // The last word of a program wraps the index. It also flags
            // completion in the first IDLE cycle.
            if (word_idx_o == IDX_LAST) begin
              word_idx_o <= '0;
              done_o     <= 1'b1;
            end else begin
              word_idx_o <= word_idx_o + 1'b1;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        default: begin
          state  <= S_IDLE;
          ser_o  <= 1'b0;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ppwm_prog_tx.sv
module tb_ppwm_prog_tx;
  localparam int W = 6;
`ifdef PPWM_PROG_TX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] word = '0, word_b = '0;
  logic         vld = 1'b0, vld_b = 1'b0;
  logic         rdy, ser, busy, done;
  logic         rdy_b, ser_b, busy_b, done_b;
  logic [4:0]   idx, idx_b;
  int           checks = 0, failures = 0;
  int           cyc = 0, done_cnt = 0;
  logic         exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

  ppwm_prog_tx #(.WIDTH(6), .DEPTH(32), .CLKS_PER_BIT(1), .GAP_BITS(1)) dut (
    .clk(clk), .rst(rst), .word_i(word), .word_valid_i(vld), .word_ready_o(rdy),
    .ser_o(ser), .busy_o(busy), .word_idx_o(idx), .done_o(done));

  ppwm_prog_tx #(.WIDTH(6), .DEPTH(32), .CLKS_PER_BIT(3), .GAP_BITS(2)) dut_b (
    .clk(clk), .rst(rst), .word_i(word_b), .word_valid_i(vld_b), .word_ready_o(rdy_b),
    .ser_o(ser_b), .busy_o(busy_b), .word_idx_o(idx_b), .done_o(done_b));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Send one word on the default-timing instance. The expected line pattern
  // is queued at the handshake and checked one cycle at a time. With hold=1,
  // valid stays high after the handshake. In both cases word_i is scrambled
  // during the frame.
  task automatic send(input logic [W-1:0] w, input bit hold, output int hs_at);
    int n = 0;
    while (rdy !== 1'b1 && n < 50) begin tick(); n++; end
    chk("ready_before_hs", rdy, 1);
    word = w; vld = 1'b1;
    tick();
    hs_at = cyc;
    vld = hold; word = ~w;
    exp_q.push_back(1'b1);
    for (int k = 0; k < W; k++) exp_q.push_back(w[k]);
    if (PB == 1) exp_q.push_back(^w);
    exp_q.push_back(1'b0);
    while (exp_q.size() > 0) begin
      chk("ser_bit", ser, exp_q.pop_front());
      chk("ready_low_in_frame", rdy, 0);
      chk("busy_in_frame", busy, 1);
      tick();
    end
    vld = 1'b0;
    chk("ready_after_frame", rdy, 1);
    chk("busy_after_frame", busy, 0);
  endtask

  initial begin
    int hs, prev_hs;
    // reset state
    #1 rst = 1'b1;
    #2;
    chk("rst_ser", ser, 0); chk("rst_busy", busy, 0); chk("rst_done", done, 0);
    chk("rst_idx", idx, 0); chk("rst_ready", rdy, 0);
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("ready_after_rst", rdy, 1);
    chk("ser_idle", ser, 0);
    tick();

    // single word 101101
    send(6'b101101, 1'b0, hs);
    chk("idx_after_one", idx, 1);

    // valid dropped for 5 idle cycles between words; the line stays low
    send(6'h2A, 1'b0, hs);
    for (int i = 0; i < 5; i++) begin
      chk("idle_ser_low", ser, 0);
      chk("idle_ready", rdy, 1);
      tick();
    end
    send(6'h15, 1'b0, hs);
    chk("idx_after_three", idx, 3);

    // reset in data bit 3
    word = 6'h3F; vld = 1'b1;
    tick();
    vld = 1'b0;
    repeat (4) tick();
    chk("pre_rst_ser", ser, 1); chk("pre_rst_busy", busy, 1);
    rst = 1'b1;
    #1;
    chk("midrst_ser", ser, 0); chk("midrst_busy", busy, 0);
    chk("midrst_idx", idx, 0); chk("midrst_ready", rdy, 0);
    tick();
    chk("midrst_ready_held", rdy, 0);
    rst = 1'b0;
    #1;
    chk("postrst_ready", rdy, 1);
    tick();

    // full program: 32 words, valid held high
    done_cnt = 0;
    prev_hs = 0;
    for (int i = 0; i < 32; i++) begin
      chk("prog_idx", idx, i);
      send(W'(i), 1'b1, hs);
      if (i > 0) chk("prog_spacing", hs - prev_hs, 9 + PB);
      prev_hs = hs;
      if (i < 31) chk("no_early_done", done, 0);
    end
    chk("prog_done_pulse", done, 1);
    chk("prog_idx_wrap", idx, 0);
    tick();
    chk("prog_done_cleared", done, 0);
    tick();
    chk("prog_done_once", done_cnt, 1);

    // stretched timing: 3 clocks per bit, 2 gap bits, word 3F
    chk("b_ready", rdy_b, 1);
    word_b = 6'h3F; vld_b = 1'b1;
    tick();
    vld_b = 1'b0; word_b = '0;
    for (int i = 0; i < 3; i++) exp_q.push_back(1'b1);
    for (int i = 0; i < 18; i++) exp_q.push_back(1'b1);
    for (int i = 0; i < 3 * PB; i++) exp_q.push_back(1'b0);
    for (int i = 0; i < 6; i++) exp_q.push_back(1'b0);
    while (exp_q.size() > 0) begin
      chk("b_ser", ser_b, exp_q.pop_front());
      chk("b_ready_low", rdy_b, 0);
      tick();
    end
    chk("b_ready_after", rdy_b, 1);
    chk("b_busy_after", busy_b, 0);
    chk("b_idx", idx_b, 1);
    chk("b_done", done_b, 0);

`ifdef PPWM_PROG_TX_PARITY_EN
    // parity build: word 000111 has parity 1 at T+8, then the gap at T+9
    send(6'b000111, 1'b0, hs);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/ppwm_prog_tx.md
# ppwm_prog_tx

Serial programming transmitter for the ppwm instruction memory. It accepts instruction words from a host-side valid/ready stream and drives them onto the single-wire programming line, which feeds the ppwm `data_i` pin. Each word goes out as a high start bit followed by the data bits, LSB first, then a low gap. After `DEPTH` words it flags completion; at that point the receiving memory considers itself programmed.

## Interface
- `WIDTH`, 6: instruction word width in bits.
- `DEPTH`, 32: words per complete program; must be ≥ 2.
- `CLKS_PER_BIT`, 1: clock cycles per serial bit; must be ≥ 1.
- `GAP_BITS`, 1: low idle bit periods after each frame; must be ≥ 1.

Ports:
- `clk` in 1: single clock; all state is on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `word_i` in `WIDTH`: instruction word to send.
- `word_valid_i` in 1: `word_i` is valid.
- `word_ready_o` out 1: block accepts a word this cycle.
- `ser_o` out 1: serial programming line; idle low.
- `busy_o` out 1: a frame or gap is in progress.
- `word_idx_o` out `$clog2(DEPTH)`: index of the next word to be accepted.
- `done_o` out 1: one-cycle pulse after the last gap of word `DEPTH-1`.

## Operation
- The FSM has five states: IDLE, START, DATA, PAR (macro only) and GAP.
- **IDLE**
  - `word_ready_o` = 1 and `ser_o` = 0.
  - On `word_valid_i && word_ready_o`, latch `word_i` into the shift register, clear the bit counters and go to START.
- **START**: `ser_o` = 1 for `CLKS_PER_BIT` cycles, then go to DATA.
- **DATA**
  - `ser_o` = shreg[0] for `CLKS_PER_BIT` cycles per bit.
  - Shift right after each bit.
  - After `WIDTH` bits, go to PAR if the macro is enabled, else go to GAP.
- **GAP**
  - `ser_o` = 0 for `GAP_BITS*CLKS_PER_BIT` cycles.
  - When the gap finishes, `word_idx_o` increments and the FSM returns to IDLE.
- **Wrap-around**: when the finishing gap belongs to word `DEPTH-1`, `word_idx_o` wraps to 0 and `done_o` is registered high for the next cycle only.
- **Outputs**
  - `word_ready_o` is 0 in every state except IDLE, and is forced to 0 while `rst` is high.
  - `busy_o` = (state != IDLE).
  - `ser_o`, `busy_o` and `done_o` are registered outputs.
- **Input stability**: `word_i` is sampled only on the handshake. Changes to `word_i` or `word_valid_i` during a frame have no effect.
- **Idle host**: if `word_valid_i` is low, IDLE holds indefinitely with the line low. Inter-word spacing is therefore ≥ the gap, never less.
- **Reset**
  - Values while in reset: state IDLE, `ser_o` 0, `busy_o` 0, `done_o` 0, `word_idx_o` 0, shift register 0.
  - Reset mid-frame drops the line low immediately. The receiver must be reset alongside; no partial-frame recovery exists.

## Timing
- Frame length is (1 + `WIDTH` [+1 parity]) × `CLKS_PER_BIT` cycles, plus `GAP_BITS`×`CLKS_PER_BIT` gap cycles.
- Handshake at cycle T produces:
  - start bit from T+1;
  - data bit k at T+1+(1+k)·`CLKS_PER_BIT`.
- Defaults, no parity:
  - start at T+1;
  - bits 0..5 at T+2..T+7;
  - gap at T+8;
  - IDLE with ready high at T+9.
  - Back-to-back maximum rate is one word per 9 cycles.
- `done_o` is high in the cycle after the final gap cycle, i.e. the first IDLE cycle. The next handshake may occur in that same cycle and begins a new program at index 0.
- `word_idx_o` updates on the same edge that returns to IDLE.

## Configuration
- Macro `PPWM_PROG_TX_PARITY_EN`.
- **Defined**
  - The PAR state sends one even-parity bit (XOR of all `WIDTH` data bits) for `CLKS_PER_BIT` cycles between DATA and GAP.
  - The frame grows by one bit period.
  - The receiver must be built with matching parity checking.
- **Undefined**: no PAR state and no parity logic; frames are exactly start + `WIDTH` data bits.

## Test plan
- **Single word**: after reset, send `word_i`=6'b101101 with valid at cycle T. Required response:
  - `ser_o` = 1,1,0,1,1,0,1,0 over T+1..T+8;
  - `word_ready_o` = 0 over T..T+8 after acceptance, and high at T+9.
- **Full program**: stream 32 words 0..31 with valid held high.
  - Handshakes occur every 9 cycles.
  - `done_o` pulses exactly once, in the cycle after the 32nd gap.
  - `word_idx_o` goes 0→31→0.
- **Stretched timing**: `CLKS_PER_BIT`=3, `GAP_BITS`=2, word 6'h3F.
  - Start bit: 3 cycles high.
  - Data: 18 cycles high.
  - Gap: 6 cycles low.
  - Next ready follows 28 cycles after the handshake.
- **Valid toggling**: drop valid for 5 cycles between words and change `word_i` mid-frame. Required response:
  - the line stays low while idle;
  - the transmitted bits equal the value sampled at the handshake.
- **Reset mid-DATA**: assert `rst` at bit 3 of a frame. Required response:
  - `ser_o`, `busy_o` and `word_idx_o` go to 0 asynchronously;
  - `word_ready_o` stays 0 while `rst` is high and returns high after release.
- **Parity build**: with `PPWM_PROG_TX_PARITY_EN` defined, send word 6'b000111. A parity bit of 1 is required at T+8, and the gap follows at T+9.
